saradc_sar_ctrl: RTL and testbench

- Parametrised digital SAR controller that drives the SAR ADC capacitive DAC switch cells and sampling switch, and resolves one bit per clock from the comparator decision.
- Successor to the fixed-function SAR logic. Adds configurable resolution, a configurable sampling window, power-of-two oversampling/averaging, and a valid/ready result handshake with back-pressure.
- Sits between the analog macro (sampling switch, DAC drivers, comparator) and the digital consumer of conversion results.

---
 rtl/saradc_sar_ctrl.sv | 99 +++++++++
 tb/tb_saradc_sar_ctrl.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/saradc_sar_ctrl.sv
// saradc_sar_ctrl: parametrised SAR conversion controller with power-of-two averaging
// and a valid/ready result handshake.
module saradc_sar_ctrl #(
    parameter int NBITS      = 8,
    parameter int SAMPLE_CYC = 2,
    parameter int AVG_LOG2   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             comp_i,
    output logic             sample_o,
    output logic [NBITS-1:0] dac_o,
    output logic             busy_o,
    output logic [NBITS-1:0] data_o,
    output logic             valid_o,
    input  logic             ready_i
);
    typedef enum logic [1:0] {IDLE, SAMPLE, CONV, DONE} state_e;
    localparam int AW = NBITS + AVG_LOG2;
    localparam logic [AVG_LOG2:0] LAST = (AVG_LOG2 + 1)'((1 << AVG_LOG2) - 1);
    state_e              state_q, state_d;
    logic [4:0]          cnt_q, cnt_d;
    logic [NBITS-1:0]    code_q, code_d, trial, code_new, data_q, data_d;
    logic [AW-1:0]       acc_q, acc_d, acc_sum;
    logic [AVG_LOG2:0]   nconv_q, nconv_d;
    logic                busy_q;
    // cnt_q counts sampling cycles in SAMPLE and holds the bit index in CONV
    assign trial    = code_q | (NBITS'(1) << cnt_q);
    assign code_new = comp_i ? trial : code_q;
    assign acc_sum  = acc_q + AW'(code_new);
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            code_q  <= '0;
            acc_q   <= '0;
            nconv_q <= '0;
            data_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
            acc_q   <= acc_d;
            nconv_q <= nconv_d;
            data_q  <= data_d;
            busy_q  <= state_d != IDLE;
        end
    end
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        code_d  = code_q;
        acc_d   = acc_q;
        nconv_d = nconv_q;
        data_d  = data_q;
        case (state_q)
            IDLE: if (start_i) begin
                state_d = SAMPLE;
                cnt_d   = '0;
                acc_d   = '0;
                nconv_d = '0;
            end
            SAMPLE: if (cnt_q == 5'(SAMPLE_CYC - 1)) begin
                state_d = CONV;
                cnt_d   = 5'(NBITS - 1);
                code_d  = '0;
            end else begin
                cnt_d = cnt_q + 5'd1;
            end
            CONV: begin
                code_d = code_new;
                cnt_d  = cnt_q - 5'd1;
                if (cnt_q == '0) begin
                    acc_d   = acc_sum;
                    nconv_d = nconv_q + 1'b1;
                    cnt_d   = '0;
                    state_d = nconv_q == LAST ? DONE : SAMPLE;
                    data_d  = nconv_q == LAST ? NBITS'(acc_sum >> AVG_LOG2) : data_q;
                end
            end
            DONE: if (ready_i) begin
                state_d = start_i ? SAMPLE : IDLE;
                cnt_d   = '0;
                acc_d   = '0;
                nconv_d = '0;
            end
            default: state_d = IDLE;
        endcase
    end
    always_comb begin
        sample_o = state_q == SAMPLE;
        dac_o    = state_q == CONV ? trial : '0;
        valid_o  = state_q == DONE;
        busy_o   = busy_q;
        data_o   = data_q;
    end
endmodule

// File: tb/tb_saradc_sar_ctrl.sv
// tb_saradc_sar_ctrl: randomized bench over several parameter sets, with an ideal
// comparator and a binary-search / averaging reference model.
module tb_saradc_sar_ctrl;
    localparam int NI = 6;
    localparam int NB_C[NI] = '{8, 8, 2, 12, 16, 16};
    localparam int SC_C[NI] = '{2, 2, 1, 15, 1, 15};
    localparam int AL_C[NI] = '{0, 2, 0, 1, 0, 4};
    logic        clk, rst;
    logic        start[NI], ready[NI], comp[NI];
    logic        sample_w[NI], busy_w[NI], valid_w[NI];
    logic [15:0] dac_w[NI], data_w[NI], vin[NI];
    int          mode[NI];
    logic [15:0] vq[16];
    int          n_cmp, n_bad, last_exp;
    for (genvar i = 0; i < NI; i++) begin : g_dut
        localparam int NB = NB_C[i];
        logic [NB-1:0] d, q;
        saradc_sar_ctrl #(.NBITS(NB), .SAMPLE_CYC(SC_C[i]), .AVG_LOG2(AL_C[i])) u_dut (
            .clk(clk), .rst(rst), .start_i(start[i]), .comp_i(comp[i]),
            .sample_o(sample_w[i]), .dac_o(d), .busy_o(busy_w[i]),
            .data_o(q), .valid_o(valid_w[i]), .ready_i(ready[i])
        );
        assign dac_w[i]  = 16'(d);
        assign data_w[i] = 16'(q);
        // mode 0: ideal comparator on vin, 1: stuck low, 2: stuck high
        assign comp[i] = mode[i] == 1 ? 1'b0 : mode[i] == 2 ? 1'b1 : (vin[i] >= dac_w[i]);
    end
    initial clk = 1'b0;
    always #5 clk = ~clk;
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    // Issues start now and checks every cycle up to the first valid cycle.
    task automatic run_conv(input int g, input int n);
        int  nb, sc, al;
        longint sum;
        nb = NB_C[g]; sc = SC_C[g]; al = AL_C[g]; sum = 0;
        start[g] = 1'b1;
        tick();
        start[g] = 1'b0;
        for (int k = 0; k < n; k++) begin
            vin[g] = vq[k];
            for (int s = 0; s < sc; s++) begin
                check("sample_hi", sample_w[g], 1);
                check("sample_dac", dac_w[g], 0);
                check("busy", busy_w[g], 1);
                check("valid_lo", valid_w[g], 0);
                tick();
            end
            for (int b = nb - 1; b >= 0; b--) begin
                check("dac_trial", dac_w[g], ((int'(vq[k]) >> (b + 1)) << (b + 1)) | (1 << b));
                check("conv_sample_lo", sample_w[g], 0);
                check("conv_valid_lo", valid_w[g], 0);
                tick();
            end
            sum += longint'(vq[k]);
        end
        last_exp = int'(sum >> al);
        check("valid", valid_w[g], 1);
        check("data", data_w[g], last_exp);
        check("done_dac", dac_w[g], 0);
        check("done_busy", busy_w[g], 1);
    endtask
    task automatic finish_idle(input int g);
        tick();
        check("valid_drop", valid_w[g], 0);
        check("idle_busy", busy_w[g], 0);
        check("idle_dac", dac_w[g], 0);
        check("data_keep", data_w[g], last_exp);
    endtask
    task automatic rand_runs(input int g, input int runs);
        for (int r = 0; r < runs; r++) begin
            for (int k = 0; k < (1 << AL_C[g]); k++) vq[k] = 16'($urandom & ((1 << NB_C[g]) - 1));
            run_conv(g, 1 << AL_C[g]);
            finish_idle(g);
        end
    endtask
    initial begin
        n_cmp = 0; n_bad = 0; last_exp = 0;
        rst = 1'b1;
        for (int g = 0; g < NI; g++) begin
            start[g] = 1'b0; ready[g] = 1'b1; mode[g] = 0; vin[g] = '0;
        end
        tick(); tick();
        rst = 1'b0;
        for (int g = 0; g < NI; g++) begin
            check("rst_sample", sample_w[g], 0);
            check("rst_dac", dac_w[g], 0);
            check("rst_busy", busy_w[g], 0);
            check("rst_data", data_w[g], 0);
            check("rst_valid", valid_w[g], 0);
        end
        vq[0] = 16'hA5;
        run_conv(0, 1);
        finish_idle(0);
        mode[0] = 1; vq[0] = 16'h00;
        run_conv(0, 1);
        finish_idle(0);
        mode[0] = 2; vq[0] = 16'hFF;
        run_conv(0, 1);
        finish_idle(0);
        mode[0] = 0;
        ready[0] = 1'b0;
        vq[0] = 16'($urandom_range(0, 255));
        run_conv(0, 1);
        for (int c = 0; c < 5; c++) begin
            start[0] = c[0];
            check("bp_valid", valid_w[0], 1);
            check("bp_data", data_w[0], last_exp);
            check("bp_busy", busy_w[0], 1);
            check("bp_sample", sample_w[0], 0);
            tick();
        end
        start[0] = 1'b0;
        check("bp_valid_end", valid_w[0], 1);
        ready[0] = 1'b1;
        vq[0] = 16'($urandom_range(0, 255));
        run_conv(0, 1);
        finish_idle(0);
        vin[0] = 16'h5A;
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        for (int c = 0; c < 5; c++) tick();
        check("pre_rst_dac", dac_w[0], 16'h50);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_sample", sample_w[0], 0);
        check("mid_rst_dac", dac_w[0], 0);
        check("mid_rst_busy", busy_w[0], 0);
        check("mid_rst_data", data_w[0], 0);
        check("mid_rst_valid", valid_w[0], 0);
        for (int c = 0; c < 12; c++) begin
            tick();
            check("post_rst_valid", valid_w[0], 0);
            check("post_rst_busy", busy_w[0], 0);
        end
        rand_runs(0, 6);
        vq[0] = 16'd10; vq[1] = 16'd11; vq[2] = 16'd12; vq[3] = 16'd13;
        run_conv(1, 4);
        finish_idle(1);
        rand_runs(1, 2);
        for (int g = 2; g < NI; g++) rand_runs(g, g == 5 ? 2 : 4);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
